// File: rtl/event_arbiter.sv
// Event arbiter: NUM_REQ pads share one seven-segment display and play a four-step animation.
// Define EVENT_ARBITER_ROUND_ROBIN_EN for rotating priority; otherwise pad 0 has fixed top priority.
module event_arbiter #(
    parameter int unsigned STEP_CYCLES = 4,
    parameter int unsigned NUM_REQ     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] button_inp,
    output logic [6:0]         seven_seg,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic               done_pulse
);

    localparam logic [7:0] LastCnt = 8'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StHold
    } state_e;

    state_e             state_q;
    logic [1:0]         step_q;
    logic [7:0]         cnt_q;
    logic               req_any;
    logic               granted_held;
    logic [1:0]         win_idx;
    logic [NUM_REQ-1:0] win_onehot;

    // Segment image for each animation step; each step lights more segments.
    function automatic logic [6:0] step_seg(input logic [1:0] s);
        logic [6:0] seg;
        case (s)
            2'd0:    seg = 7'h60;
            2'd1:    seg = 7'h78;
            2'd2:    seg = 7'h7E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    assign req_any      = |button_inp;
    assign granted_held = |(button_inp & grant);
    assign win_onehot   = NUM_REQ'(1) << win_idx;

`ifdef EVENT_ARBITER_ROUND_ROBIN_EN
    logic [1:0] ptr_q;
    logic [1:0] cand;
    logic       found;

    // Search starts at the pointer and wraps around the pads.
    always_comb begin
        win_idx = ptr_q;
        cand    = ptr_q;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr_q + k[1:0];
            if (!found && button_inp[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else if (state_q == StIdle && req_any) begin
            ptr_q <= win_idx + 2'd1;
        end
    end
`else
    // Descending scan so the lowest requesting index wins.
    always_comb begin
        win_idx = 2'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (button_inp[k]) begin
                win_idx = k[1:0];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            step_q     <= 2'd0;
            cnt_q      <= 8'd0;
            seven_seg  <= 7'h00;
            grant      <= '0;
            busy       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_any) begin
                        state_q   <= StPlay;
                        grant     <= win_onehot;
                        step_q    <= 2'd0;
                        cnt_q     <= 8'd0;
                        seven_seg <= step_seg(2'd0);
                        busy      <= 1'b1;
                    end
                end
                StPlay: begin
                    // Releasing the granted pad wins over any step advance on the same edge.
                    if (!granted_held) begin
                        state_q   <= StIdle;
                        grant     <= '0;
                        step_q    <= 2'd0;
                        cnt_q     <= 8'd0;
                        seven_seg <= 7'h00;
                        busy      <= 1'b0;
                    end else if (cnt_q == LastCnt) begin
                        cnt_q <= 8'd0;
                        if (step_q == 2'd3) begin
                            state_q    <= StHold;
                            step_q     <= 2'd0;
                            seven_seg  <= 7'h00;
                            done_pulse <= 1'b1;
                        end else begin
                            step_q    <= step_q + 2'd1;
                            seven_seg <= step_seg(step_q + 2'd1);
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StHold: begin
                    if (!granted_held) begin
                        state_q   <= StIdle;
                        grant     <= '0;
                        seven_seg <= 7'h00;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    grant     <= '0;
                    seven_seg <= 7'h00;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_event_arbiter.sv
// Scoreboard bench for event_arbiter: stimulus queues per-cycle expected outputs, a monitor checks them.
module tb_event_arbiter;

    localparam int unsigned S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] button_inp = 4'b0000;
    logic [6:0] seven_seg;
    logic [3:0] grant;
    logic       busy;
    logic       done_pulse;

    always #5 clk = ~clk;

    event_arbiter #(
        .STEP_CYCLES(S),
        .NUM_REQ    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .button_inp(button_inp),
        .seven_seg (seven_seg),
        .grant     (grant),
        .busy      (busy),
        .done_pulse(done_pulse)
    );

    typedef struct {
        string      name;
        logic [6:0] seg;
        logic [3:0] gnt;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [6:0] pat [4] = '{7'h60, 7'h78, 7'h7E, 7'h7F};
    logic [3:0] rr_g [5];

    // Apply inputs for one edge and queue the outputs expected after it.
    task automatic cyc(input logic [3:0] btn, input logic r, input string nm,
                       input logic [6:0] seg, input logic [3:0] g, input logic b,
                       input logic d);
        exp_t e;
        button_inp = btn;
        rst        = r;
        @(posedge clk);
        #1;
        e.name = nm;
        e.seg  = seg;
        e.gnt  = g;
        e.busy = b;
        e.done = d;
        exp_q.push_back(e);
    endtask

    // Cycles from..to-1 counted from the grant edge, granted pad held.
    task automatic play(input logic [3:0] btn, input logic [3:0] g, input string nm,
                        input int from, input int to);
        for (int i = from; i < to; i++) begin
            cyc(btn, 1'b0, nm, pat[i / S], g, 1'b1, 1'b0);
        end
    endtask

    task automatic finish_anim(input logic [3:0] btn, input logic [3:0] g, input string nm);
        cyc(btn, 1'b0, nm, 7'h00, g, 1'b1, 1'b1);
        cyc(btn, 1'b0, nm, 7'h00, g, 1'b1, 1'b0);
        cyc(btn, 1'b0, nm, 7'h00, g, 1'b1, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (seven_seg !== e.seg || grant !== e.gnt || busy !== e.busy
                || done_pulse !== e.done) begin
                n_fail++;
                $display("FAIL %s: got seg=%h grant=%b busy=%b done=%b, expected seg=%h grant=%b busy=%b done=%b",
                         e.name, seven_seg, grant, busy, done_pulse,
                         e.seg, e.gnt, e.busy, e.done);
            end
        end
    end

    initial begin
`ifdef EVENT_ARBITER_ROUND_ROBIN_EN
        rr_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        rr_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        cyc(4'b0000, 1'b1, "reset", 7'h00, 4'b0000, 1'b0, 1'b0);
        cyc(4'b0000, 1'b1, "reset", 7'h00, 4'b0000, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, "idle", 7'h00, 4'b0000, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, "idle", 7'h00, 4'b0000, 1'b0, 1'b0);

        // Full animation for pad 2, then release from HOLD.
        play(4'b0100, 4'b0100, "single_play", 0, 4 * S);
        finish_anim(4'b0100, 4'b0100, "single_hold");
        cyc(4'b0000, 1'b0, "single_release", 7'h00, 4'b0000, 1'b0, 1'b0);

        // Pad 1 released during step2 aborts without done.
        play(4'b0010, 4'b0010, "abort_play", 0, 2 * S + 1);
        cyc(4'b0000, 1'b0, "abort", 7'h00, 4'b0000, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, "abort_idle", 7'h00, 4'b0000, 1'b0, 1'b0);

        // All pads requesting, repeated complete animations.
        cyc(4'b0000, 1'b1, "rr_reset", 7'h00, 4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            play(4'b1111, rr_g[k], "rr_play", 0, 4 * S);
            finish_anim(4'b1111, rr_g[k], "rr_hold");
            cyc(4'b0000, 1'b0, "rr_release", 7'h00, 4'b0000, 1'b0, 1'b0);
        end

        // Pad 3 pressed mid-PLAY is not queued; granted only after pad 0 leaves HOLD.
        play(4'b0001, 4'b0001, "noq_play", 0, 6);
        play(4'b1001, 4'b0001, "noq_play", 6, 4 * S);
        finish_anim(4'b1001, 4'b0001, "noq_hold");
        cyc(4'b1000, 1'b0, "noq_release", 7'h00, 4'b0000, 1'b0, 1'b0);
        cyc(4'b1000, 1'b0, "noq_regrant", 7'h60, 4'b1000, 1'b1, 1'b0);
        play(4'b1000, 4'b1000, "noq_play3", 1, 3);
        cyc(4'b0000, 1'b0, "noq_abort", 7'h00, 4'b0000, 1'b0, 1'b0);

        // Reset during step1; re-grant must use the reset pointer (pad 1, not pad 3).
        cyc(4'b0000, 1'b1, "rst_pre", 7'h00, 4'b0000, 1'b0, 1'b0);
        play(4'b1010, 4'b0010, "rst_play", 0, S + 2);
        cyc(4'b1010, 1'b1, "rst_mid", 7'h00, 4'b0000, 1'b0, 1'b0);
        cyc(4'b1010, 1'b0, "rst_regrant", 7'h60, 4'b0010, 1'b1, 1'b0);
        play(4'b1010, 4'b0010, "rst_play2", 1, S + 1);
        cyc(4'b0000, 1'b0, "rst_abort", 7'h00, 4'b0000, 1'b0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/event_arbiter.md
EVENT_ARBITER -- requirements
Module: event_arbiter

Interface
REQ-001 The block SHALL have parameter STEP_CYCLES, default 4, meaning clock cycles each animation step is held (legal range 1..255).
REQ-002 The block SHALL have parameter NUM_REQ, fixed at 4, meaning the number of pad requesters sharing the display.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port button_inp, input, 4 bits, the pad request levels; bit i high means pad i requests the display.
REQ-006 The block SHALL have port seven_seg, output, 7 bits, the shared segment drive; bit 6 is segment a and bit 0 is segment g.
REQ-007 The block SHALL have port grant, output, 4 bits, one-hot or zero, identifying the pad that owns the display.
REQ-008 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-009 The block SHALL have port done_pulse, output, 1 bit, high for exactly one cycle when an animation completes without abort.

Function
REQ-010 The block SHALL implement a state machine with states IDLE, PLAY and HOLD, and all outputs SHALL be registered.
REQ-011 IDLE: if any button_inp bit is high at an edge, the winner SHALL be latched, grant SHALL be set one-hot, state SHALL go to PLAY with step=0 and cycle counter=0, and seven_seg=7'h60 SHALL be visible after that same edge (1-cycle request-to-display latency).
REQ-012 IDLE with no request: seven_seg=0, grant=0, busy=0.
REQ-013 PLAY step patterns SHALL be cumulative: step0 7'h60, step1 7'h78, step2 7'h7E, step3 7'h7F.
REQ-014 Each step SHALL last exactly STEP_CYCLES cycles; the step advances when the cycle counter reaches STEP_CYCLES-1, and the counter then wraps to 0.
REQ-015 At the end of step3, state SHALL go to HOLD, seven_seg SHALL go to 0, and done_pulse SHALL assert for one cycle; total PLAY time is 4*STEP_CYCLES cycles.
REQ-016 HOLD: grant SHALL stay asserted and seven_seg SHALL be 0 until the granted bit is low, then state SHALL go to IDLE with grant=0; this blocks retrigger while held.
REQ-017 If the granted button_inp bit is low at any PLAY edge, that edge SHALL abort to IDLE: seven_seg=0, grant=0, no done_pulse.
REQ-018 Requests from non-granted pads during PLAY or HOLD SHALL be ignored, not queued.
REQ-019 A re-request in the same cycle that HOLD or an abort returns to IDLE SHALL be arbitrated on the following edge, not the same edge.

Reset
REQ-020 When rst is high at an edge, the block SHALL set state=IDLE, seven_seg=0, grant=0, busy=0, done_pulse=0, counters=0, and the round-robin pointer=0, overriding all other events.
REQ-021 A reset asserted mid-PLAY SHALL abort the animation with no done_pulse; the first arbitration after rst deasserts uses the reset pointer.

Configuration
REQ-022 Macro EVENT_ARBITER_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-023 With the macro defined: a rotating-priority search SHALL start at the pointer; on each grant the pointer SHALL be set to (winner+1) mod 4.
REQ-024 Without the macro: fixed priority SHALL apply (bit 0 highest, bit 3 lowest) and no pointer register SHALL exist.

Verification
REQ-025 Reset, then button_inp=4'b0100 held with STEP_CYCLES=4 -> grant=0100 after 1 edge; seven_seg 60,78,7E,7F at 4-cycle intervals; then 0 with done_pulse for one cycle and busy=1 held until release.
REQ-026 Pad 1 granted, released during step2 -> next edge seven_seg=0, grant=0, busy=0, done_pulse never high.
REQ-027 button_inp=4'b1111 repeatedly, each animation run to completion and released -> grants 0001,0010,0100,1000,0001 with the macro defined; always 0001 without it.
REQ-028 Pad 0 granted, pad 3 pressed mid-PLAY and held -> grant stays 0001; after pad 0 release from HOLD, pad 3 is granted on the following edge.
REQ-029 rst pulsed for one cycle during step1 -> all outputs 0 after that edge; with pad still held, re-grant occurs on the next edge after rst deasserts.
